// File: rtl/fp_align_add.sv
// fp_align_add: exponent alignment and mantissa add/subtract front end for
// IEEE-754 single precision. The larger-magnitude operand X is kept as is,
// the smaller operand Y is shifted right one bit per ALIGN cycle, and ADD
// produces an un-normalized sign/exponent/mantissa/carry for a downstream
// normalizer.
// Optional feature macro: ALIGN_STICKY_EN (collect shifted-out bits into a
// sticky bit that is folded into mY[0] before the add/subtract).

module fp_align_add #(
  parameter int MAX_ALIGN = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        ready,
  output logic        done,
  output logic        sign_out,
  output logic [7:0]  e_out,
  output logic [23:0] mant_out,
  output logic        cout
);

  localparam int CW = (MAX_ALIGN < 1) ? 1 : $clog2(MAX_ALIGN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operand working registers
  logic          r_sx;
  logic          r_sy;
  logic [7:0]    r_ex;
  logic [23:0]   r_mx;
  logic [23:0]   r_my;
  logic [CW-1:0] r_cnt;
`ifdef ALIGN_STICKY_EN
  logic          r_sticky;
`endif

  // Result registers
  logic          r_sign_out;
  logic [7:0]    r_e_out;
  logic [23:0]   r_mant_out;
  logic          r_cout;

  // Operand decode: denormals get hidden bit 0 and effective exponent 1
  logic          w_a_exp_nz;
  logic          w_b_exp_nz;
  logic [7:0]    w_a_exp;
  logic [7:0]    w_b_exp;
  logic [23:0]   w_a_mant;
  logic [23:0]   w_b_mant;
  logic          w_a_ge_b;
  logic          w_sx;
  logic          w_sy;
  logic [7:0]    w_ex;
  logic [7:0]    w_ey;
  logic [23:0]   w_mx;
  logic [23:0]   w_my;
  logic [7:0]    w_d;
  logic          w_d_fits;
  logic [CW-1:0] w_cnt_load;

  assign w_a_exp_nz = |a_in[30:23];
  assign w_b_exp_nz = |b_in[30:23];
  assign w_a_exp    = w_a_exp_nz ? a_in[30:23] : 8'd1;
  assign w_b_exp    = w_b_exp_nz ? b_in[30:23] : 8'd1;
  assign w_a_mant   = {w_a_exp_nz, a_in[22:0]};
  assign w_b_mant   = {w_b_exp_nz, b_in[22:0]};

  // Magnitude compare on exponent then mantissa; ties keep A as X
  assign w_a_ge_b = {w_a_exp, w_a_mant} >= {w_b_exp, w_b_mant};

  assign w_sx = w_a_ge_b ? a_in[31] : b_in[31];
  assign w_sy = w_a_ge_b ? b_in[31] : a_in[31];
  assign w_ex = w_a_ge_b ? w_a_exp  : w_b_exp;
  assign w_ey = w_a_ge_b ? w_b_exp  : w_a_exp;
  assign w_mx = w_a_ge_b ? w_a_mant : w_b_mant;
  assign w_my = w_a_ge_b ? w_b_mant : w_a_mant;

  // Differences beyond MAX_ALIGN skip shifting entirely and flush mY
  assign w_d        = w_ex - w_ey;
  assign w_d_fits   = int'(w_d) <= MAX_ALIGN;
  assign w_cnt_load = w_d_fits ? CW'(w_d) : '0;

  // Add/subtract datapath on the aligned mantissas
  logic [23:0] w_my_eff;
  logic [24:0] w_sum;
  logic [23:0] w_diff;
  logic        w_eff_sub;

`ifdef ALIGN_STICKY_EN
  assign w_my_eff = {r_my[23:1], r_my[0] | r_sticky};
`else
  assign w_my_eff = r_my;
`endif

  assign w_sum     = {1'b0, r_mx} + {1'b0, w_my_eff};
  assign w_diff    = r_mx - w_my_eff;
  assign w_eff_sub = r_sx ^ r_sy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ALIGN;
      S_ALIGN: if (r_cnt == '0) w_state_next = S_ADD;
      S_ADD:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, one-bit-per-cycle alignment shift, and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_ex       <= '0;
      r_mx       <= '0;
      r_my       <= '0;
      r_cnt      <= '0;
`ifdef ALIGN_STICKY_EN
      r_sticky   <= 1'b0;
`endif
      r_sign_out <= 1'b0;
      r_e_out    <= '0;
      r_mant_out <= '0;
      r_cout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sx  <= w_sx;
            r_sy  <= w_sy;
            r_ex  <= w_ex;
            r_mx  <= w_mx;
            r_my  <= w_d_fits ? w_my : '0;
            r_cnt <= w_cnt_load;
`ifdef ALIGN_STICKY_EN
            r_sticky <= w_d_fits ? 1'b0 : (|w_my);
`endif
          end
        end
        S_ALIGN: begin
          if (r_cnt != '0) begin
            r_my  <= r_my >> 1;
            r_cnt <= r_cnt - CW'(1);
`ifdef ALIGN_STICKY_EN
            r_sticky <= r_sticky | r_my[0];
`endif
          end
        end
        S_ADD: begin
          r_e_out <= r_ex;
          if (w_eff_sub) begin
            r_mant_out <= w_diff;
            r_cout     <= 1'b0;
            r_sign_out <= (w_diff == '0) ? 1'b0 : r_sx;
          end else begin
            r_mant_out <= w_sum[24] ? w_sum[24:1] : w_sum[23:0];
            r_cout     <= w_sum[24];
            r_sign_out <= r_sx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign done     = (r_state == S_DONE);
  assign sign_out = r_sign_out;
  assign e_out    = r_e_out;
  assign mant_out = r_mant_out;
  assign cout     = r_cout;

endmodule
